// File: rtl/taxi_pkg.sv
// Shared taxi-core definitions: switch-reader FSM encoding and the default
// switch scan interval.
package taxi_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      DONE     = 3'd4
   } hc165_state_e;

   // 20 ms between scans at 50 MHz
   localparam logic [19:0] SCAN_CNT_MAX_DEFAULT = 20'd999_999;

endpackage

// File: rtl/hc165_ctrl_chk.sv
// Simulation checker for hc165_ctrl: the scan interval must be longer than
// one complete scan, and sw_changed may only pulse together with sw_valid.
module hc165_ctrl_chk
   import taxi_pkg::*;
#(
   parameter int          CHAIN_LEN    = 1,
   parameter int          CLK_DIV      = 4,
   parameter logic [19:0] SCAN_CNT_MAX = SCAN_CNT_MAX_DEFAULT
)(
   input logic clk,
   input logic rst_n,
   input logic sw_valid,
   input logic sw_changed
);

   localparam int SCAN_LEN = 2*CLK_DIV + 2*CLK_DIV*8*CHAIN_LEN + 1;

   a_scan_fits: assert property (@(posedge clk) disable iff (!rst_n)
      (int'(SCAN_CNT_MAX) + 1 > SCAN_LEN));

   a_changed_with_valid: assert property (@(posedge clk) disable iff (!rst_n)
      sw_changed |-> sw_valid);

endmodule

// File: rtl/hc165_ctrl.sv
// Periodic reader for a chain of 74HC165 shift registers holding the fare/mode
// DIP switches. Define HC165_DEBOUNCE_EN to commit only two identical scans.
module hc165_ctrl
   import taxi_pkg::*;
#(
   parameter int          CHAIN_LEN    = 1,
   parameter int          CLK_DIV      = 4,
   parameter logic [19:0] SCAN_CNT_MAX = SCAN_CNT_MAX_DEFAULT,
   localparam int         DATA_W       = 8*CHAIN_LEN
)(
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              hc165_q7,
   output logic              hc165_pl_n,
   output logic              hc165_cp,
   output logic              hc165_ce_n,
   output logic [DATA_W-1:0] sw_data,
   output logic              sw_valid,
   output logic              sw_changed,
   output logic              busy
);

   localparam int               TMR_W     = $clog2(2*CLK_DIV) + 1;
   localparam int               BIT_W     = $clog2(DATA_W) + 1;
   localparam logic [TMR_W-1:0] LOAD_LAST = TMR_W'(2*CLK_DIV - 1);
   localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

   hc165_state_e      state_r;
   hc165_state_e      state_nxt_s;
   logic [19:0]       scan_cnt_r;
   logic              scan_tick_s;
   logic [TMR_W-1:0]  tmr_r;
   logic              tmr_last_s;
   logic [BIT_W-1:0]  bit_cnt_r;
   logic [DATA_W-1:0] shreg_r;
   logic [DATA_W-1:0] sw_data_r;
   logic              commit_s;
   logic              accept_s;
   logic              pl_n_r;
   logic              cp_r;
   logic              ce_n_r;
   logic              sw_valid_r;
   logic              sw_changed_r;
   logic              busy_r;

`ifdef HC165_DEBOUNCE_EN
   logic [DATA_W-1:0] prev_r;

   assign accept_s = (shreg_r == prev_r);
`else
   assign accept_s = 1'b1;
`endif

   assign scan_tick_s = (scan_cnt_r == SCAN_CNT_MAX);
   // The word is complete when the last high half-period ends
   assign commit_s    = (state_r == SHIFT_HI) && (state_nxt_s == DONE);

   // Free-running scan interval counter; its wrap is the scan tick
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         scan_cnt_r <= 20'd0;
      end else if (scan_tick_s) begin
         scan_cnt_r <= 20'd0;
      end else begin
         scan_cnt_r <= scan_cnt_r + 20'd1;
      end
   end

   // Terminal count of the current phase timer
   always_comb begin
      tmr_last_s = 1'b0;
      case (state_r)
         LOAD:               tmr_last_s = (tmr_r == LOAD_LAST);
         SHIFT_LO, SHIFT_HI: tmr_last_s = (tmr_r == HALF_LAST);
         default:            tmr_last_s = 1'b0;
      endcase
   end

   // Next-state logic; ticks outside IDLE are simply ignored
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (scan_tick_s) state_nxt_s = LOAD;
            else             state_nxt_s = IDLE;
         end
         LOAD: begin
            if (tmr_last_s) state_nxt_s = SHIFT_LO;
            else            state_nxt_s = LOAD;
         end
         SHIFT_LO: begin
            if (tmr_last_s) state_nxt_s = SHIFT_HI;
            else            state_nxt_s = SHIFT_LO;
         end
         SHIFT_HI: begin
            if (!tmr_last_s)                state_nxt_s = SHIFT_HI;
            else if (bit_cnt_r == BIT_LAST) state_nxt_s = DONE;
            else                            state_nxt_s = SHIFT_LO;
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register, phase timer, bit counter and capture shift register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r   <= IDLE;
         tmr_r     <= '0;
         bit_cnt_r <= '0;
         shreg_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == IDLE) || (state_nxt_s != state_r)) begin
            tmr_r <= '0;
         end else begin
            tmr_r <= tmr_r + TMR_W'(1'b1);
         end
         if (state_r == LOAD) begin
            bit_cnt_r <= '0;
         end else if ((state_r == SHIFT_HI) && tmr_last_s) begin
            bit_cnt_r <= bit_cnt_r + BIT_W'(1'b1);
         end
         // Sample q7 just before cp rises; first bit lands in the MSB
         if ((state_r == SHIFT_LO) && tmr_last_s) begin
            shreg_r <= {shreg_r[DATA_W-2:0], hc165_q7};
         end
      end
   end

   // Outputs are decoded from the next state so they line up with state_r
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pl_n_r       <= 1'b1;
         cp_r         <= 1'b0;
         ce_n_r       <= 1'b1;
         busy_r       <= 1'b0;
         sw_valid_r   <= 1'b0;
         sw_changed_r <= 1'b0;
         sw_data_r    <= '0;
      end else begin
         pl_n_r       <= (state_nxt_s != LOAD);
         cp_r         <= (state_nxt_s == SHIFT_HI);
         ce_n_r       <= !((state_nxt_s == LOAD) || (state_nxt_s == SHIFT_LO) ||
                           (state_nxt_s == SHIFT_HI));
         busy_r       <= (state_nxt_s != IDLE);
         sw_valid_r   <= commit_s && accept_s;
         sw_changed_r <= commit_s && accept_s && (shreg_r != sw_data_r);
         if (commit_s && accept_s) begin
            sw_data_r <= shreg_r;
         end
      end
   end

`ifdef HC165_DEBOUNCE_EN
   // Every completed capture becomes the reference for the next scan
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         prev_r <= '0;
      end else if (commit_s) begin
         prev_r <= shreg_r;
      end
   end
`endif

   assign hc165_pl_n = pl_n_r;
   assign hc165_cp   = cp_r;
   assign hc165_ce_n = ce_n_r;
   assign busy       = busy_r;
   assign sw_valid   = sw_valid_r;
   assign sw_changed = sw_changed_r;
   assign sw_data    = sw_data_r;

endmodule

// File: tb/tb_hc165_ctrl.sv
// Bench for hc165_ctrl: three instances (8-bit chain, 16-bit chain, short scan
// interval) each driven by a behavioural 74HC165 chain model.
`timescale 1ns/1ps
module tb_hc165_ctrl;

`ifdef HC165_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
`else
   localparam bit DEB = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic rst1 = 1'b0, rst2 = 1'b0, rst3 = 1'b0;
   logic q1, pl1, cp1, ce1, v1, ch1, busy1;
   logic q2, pl2, cp2, ce2, v2, ch2, busy2;
   logic q3, pl3, cp3, ce3, v3, ch3, busy3;
   logic [7:0]  d1, d3, par1, par3, sr1, sr3;
   logic [15:0] d2, par2, sr2;

   hc165_ctrl #(.CHAIN_LEN(1), .CLK_DIV(2), .SCAN_CNT_MAX(20'd199)) u1 (
      .sys_clk(clk), .sys_rst_n(rst1), .hc165_q7(q1), .hc165_pl_n(pl1), .hc165_cp(cp1),
      .hc165_ce_n(ce1), .sw_data(d1), .sw_valid(v1), .sw_changed(ch1), .busy(busy1));
   hc165_ctrl #(.CHAIN_LEN(2), .CLK_DIV(2), .SCAN_CNT_MAX(20'd199)) u2 (
      .sys_clk(clk), .sys_rst_n(rst2), .hc165_q7(q2), .hc165_pl_n(pl2), .hc165_cp(cp2),
      .hc165_ce_n(ce2), .sw_data(d2), .sw_valid(v2), .sw_changed(ch2), .busy(busy2));
   hc165_ctrl #(.CHAIN_LEN(1), .CLK_DIV(2), .SCAN_CNT_MAX(20'd19)) u3 (
      .sys_clk(clk), .sys_rst_n(rst3), .hc165_q7(q3), .hc165_pl_n(pl3), .hc165_cp(cp3),
      .hc165_ce_n(ce3), .sw_data(d3), .sw_valid(v3), .sw_changed(ch3), .busy(busy3));

   hc165_ctrl_chk #(.CHAIN_LEN(1), .CLK_DIV(2), .SCAN_CNT_MAX(20'd199)) c1 (
      .clk(clk), .rst_n(rst1), .sw_valid(v1), .sw_changed(ch1));
   hc165_ctrl_chk #(.CHAIN_LEN(2), .CLK_DIV(2), .SCAN_CNT_MAX(20'd199)) c2 (
      .clk(clk), .rst_n(rst2), .sw_valid(v2), .sw_changed(ch2));

   // 74HC165 chain models: async parallel load, shift on cp rise while enabled
   always @(posedge cp1 or negedge pl1)
      if (!pl1) sr1 <= par1; else if (!ce1) sr1 <= {sr1[6:0], 1'b0};
   always @(posedge cp2 or negedge pl2)
      if (!pl2) sr2 <= par2; else if (!ce2) sr2 <= {sr2[14:0], 1'b0};
   always @(posedge cp3 or negedge pl3)
      if (!pl3) sr3 <= par3; else if (!ce3) sr3 <= {sr3[6:0], 1'b0};
   assign q1 = sr1[7];
   assign q2 = sr2[15];
   assign q3 = sr3[7];

   // Activity monitors
   int ecnt1 = 0, cpn1 = 0, pln1 = 0, vn1 = 0, vcyc1 = 0;
   logic chl1 = 1'b0;
   int cpn2 = 0, pln2 = 0, vn2 = 0;
   logic chl2 = 1'b0;
   int ecnt3 = 0, vn3 = 0, brise3 = 0, brun3 = 0, bbad3 = 0;
   logic bprev3 = 1'b0;

   always @(posedge clk) if (!rst1) ecnt1 <= 0; else ecnt1 <= ecnt1 + 1;
   always @(posedge clk) if (!rst3) ecnt3 <= 0; else ecnt3 <= ecnt3 + 1;
   always @(posedge cp1) cpn1 <= cpn1 + 1;
   always @(posedge cp2) cpn2 <= cpn2 + 1;
   always @(negedge clk) begin
      if (!pl1) pln1 <= pln1 + 1;
      if (v1) begin vn1 <= vn1 + 1; chl1 <= ch1; vcyc1 <= ecnt1; end
      if (!pl2) pln2 <= pln2 + 1;
      if (v2) begin vn2 <= vn2 + 1; chl2 <= ch2; end
      if (rst3) begin
         if (busy3) brun3 <= brun3 + 1;
         else begin
            if (brun3 != 0 && brun3 != 37) bbad3 <= bbad3 + 1;
            brun3 <= 0;
         end
         if (busy3 && !bprev3) brise3 <= brise3 + 1;
         bprev3 <= busy3;
         if (v3) vn3 <= vn3 + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic sel_busy(input int which);
      case (which)
         1:       return busy1;
         2:       return busy2;
         default: return busy3;
      endcase
   endfunction

   task automatic wait_busy(input int which, input logic lvl, input string nm);
      int   n;
      logic b;
      n = 0;
      b = sel_busy(which);
      while (b !== lvl && n < 500) begin
         @(negedge clk);
         n++;
         b = sel_busy(which);
      end
      if (b !== lvl) chk({nm, "_timeout"}, 32'(b), 32'(lvl));
   endtask

   typedef struct packed {
      logic [7:0] par;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_changed;
   } vec_t;

   vec_t tbl [6];
   int   c0, p0, v0, n;
   logic busy_seen;

   initial begin
`ifdef HC165_DEBOUNCE_EN
      tbl[0] = '{8'h0F, 1'b0, 8'h00, 1'b0};
      tbl[1] = '{8'hF0, 1'b0, 8'h00, 1'b0};
      tbl[2] = '{8'h0F, 1'b0, 8'h00, 1'b0};
      tbl[3] = '{8'hF0, 1'b0, 8'h00, 1'b0};
      tbl[4] = '{8'hF0, 1'b1, 8'hF0, 1'b1};
      tbl[5] = '{8'hF0, 1'b1, 8'hF0, 1'b0};
`else
      tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1};
      tbl[1] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
      tbl[2] = '{8'h3C, 1'b1, 8'h3C, 1'b1};
      tbl[3] = '{8'h00, 1'b1, 8'h00, 1'b1};
      tbl[4] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
      tbl[5] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
`endif
      par1 = 8'h00; par2 = 16'h0000; par3 = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_pl_n",   32'(pl1),   32'h1);
      chk("rst_cp",     32'(cp1),   32'h0);
      chk("rst_ce_n",   32'(ce1),   32'h1);
      chk("rst_data",   32'(d1),    32'h0);
      chk("rst_valid",  32'(v1),    32'h0);
      chk("rst_change", 32'(ch1),   32'h0);
      chk("rst_busy",   32'(busy1), 32'h0);

      // Table-driven scans on the 8-bit chain; one scan every 200 cycles
      rst1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         par1 = tbl[i].par;
         c0 = cpn1; p0 = pln1; v0 = vn1;
         wait_busy(1, 1'b1, "scan_start");
         chk("scan_start_cyc", 32'(ecnt1), 32'(200*(i+1)));
         wait_busy(1, 1'b0, "scan_end");
         chk("scan_valid_cnt", 32'(vn1 - v0), 32'(tbl[i].exp_valid));
         chk("scan_cp_edges",  32'(cpn1 - c0), 32'd8);
         chk("scan_pl_low",    32'(pln1 - p0), 32'd4);
         chk("scan_data",      32'(d1), 32'(tbl[i].exp_data));
         if (tbl[i].exp_valid) begin
            chk("scan_changed", 32'(chl1), 32'(tbl[i].exp_changed));
            chk("scan_latency", 32'(vcyc1), 32'(200*(i+1) + 36));
         end
      end

      // Reset in the middle of shifting bit 3
      wait_busy(1, 1'b1, "rst_scan_start");
      c0 = cpn1;
      n = 0;
      while (cpn1 - c0 < 3 && n < 100) begin @(negedge clk); n++; end
      chk("rst_pre_edges", 32'(cpn1 - c0), 32'd3);
      @(negedge clk); @(negedge clk);
      rst1 = 1'b0;
      #1;
      chk("mid_rst_pl_n", 32'(pl1),   32'h1);
      chk("mid_rst_cp",   32'(cp1),   32'h0);
      chk("mid_rst_ce_n", 32'(ce1),   32'h1);
      chk("mid_rst_data", 32'(d1),    32'h0);
      chk("mid_rst_vld",  32'(v1),    32'h0);
      chk("mid_rst_busy", 32'(busy1), 32'h0);
      @(negedge clk); @(negedge clk);
      par1 = 8'h5A;
      c0 = cpn1; v0 = vn1;
      rst1 = 1'b1;
      busy_seen = 1'b0;
      repeat (199) begin @(negedge clk); if (busy1) busy_seen = 1'b1; end
      chk("post_rst_quiet_busy", 32'(busy_seen), 32'h0);
      chk("post_rst_quiet_cp",   32'(cpn1 - c0), 32'h0);
      wait_busy(1, 1'b1, "post_rst_start");
      chk("post_rst_start_cyc", 32'(ecnt1), 32'd200);
      wait_busy(1, 1'b0, "post_rst_end");
      chk("post_rst_cp_edges", 32'(cpn1 - c0), 32'd8);
      chk("post_rst_valid",    32'(vn1 - v0), DEB ? 32'd0 : 32'd1);
      chk("post_rst_data",     32'(d1), DEB ? 32'h0 : 32'h5A);

      // 16-bit chain, two scans of the same word
      par2 = 16'h3C81;
      rst2 = 1'b1;
      wait_busy(2, 1'b1, "c2_start1");
      wait_busy(2, 1'b0, "c2_end1");
      chk("c2_cp_edges1", 32'(cpn2), 32'd16);
      chk("c2_pl_low1",   32'(pln2), 32'd4);
      chk("c2_valid1",    32'(vn2), DEB ? 32'd0 : 32'd1);
      chk("c2_data1",     32'(d2), DEB ? 32'h0 : 32'h3C81);
      wait_busy(2, 1'b1, "c2_start2");
      wait_busy(2, 1'b0, "c2_end2");
      chk("c2_cp_edges2", 32'(cpn2), 32'd32);
      chk("c2_valid2",    32'(vn2), DEB ? 32'd1 : 32'd2);
      chk("c2_data2",     32'(d2), 32'h3C81);
      chk("c2_changed2",  32'(chl2), 32'(DEB));

      // Scan interval shorter than a scan: busy ticks are dropped
      par3 = 8'hA5;
      rst3 = 1'b1;
      repeat (400) @(negedge clk);
      chk("short_busy_rises", 32'(brise3), 32'd10);
      chk("short_valids",     32'(vn3), DEB ? 32'd8 : 32'd9);
      chk("short_busy_runs",  32'(bbad3), 32'd0);
      chk("short_data",       32'(d3), 32'hA5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hc165_ctrl.md
Name: hc165_ctrl

Overview:
Reader-side counterpart of the 74HC595 display shifter. The block periodically scans a chain of 74HC165 parallel-in/serial-out registers, which carry DIP switches for fare rate and mode, and presents the captured word to the taxi core. It is a free-running serial reader with a one-cycle valid pulse and a change flag, and sits beside hc595_ctrl at the top level.

Parameters:
CHAIN_LEN, 1, number of cascaded 74HC165 devices; DATA_W = 8*CHAIN_LEN
CLK_DIV, 4, sys_clk cycles per half-period of hc165_cp and per half of the load pulse (must be >= 1)
SCAN_CNT_MAX, 20'd999_999, scan interval counter terminal value (20 ms at 50 MHz)

Ports:
sys_clk  in  1  system clock; the only clock
sys_rst_n  in  1  reset, asynchronous, active-low
hc165_q7  in  1  serial data from the last device in the chain
hc165_pl_n  out  1  parallel load, active-low
hc165_cp  out  1  shift clock to the chain
hc165_ce_n  out  1  clock enable, active-low
sw_data  out  DATA_W  last accepted switch word
sw_valid  out  1  one-cycle pulse when sw_data is updated
sw_changed  out  1  one-cycle pulse, coincident with sw_valid, when the new sw_data differs from the previous value
busy  out  1  high while a scan is in progress (any state other than IDLE)

Behaviour:
- All outputs and flops are cleared by the asynchronous reset, with these output values: pl_n=1, cp=0, ce_n=1, sw_data=0, sw_valid=0, sw_changed=0, busy=0.
- Scan counter: free-running from 0 to SCAN_CNT_MAX, then wraps to 0. The wrap produces scan_tick.
- If scan_tick arrives while not in IDLE, it is dropped; ticks are not queued.
- FSM state IDLE: waits for scan_tick, then goes to LOAD.
- FSM state LOAD: pl_n=0 and ce_n=0 for 2*CLK_DIV cycles, then goes to SHIFT_LO.
- FSM state SHIFT_LO: pl_n=1, cp=0 for CLK_DIV cycles. On the last cycle, q7 is shifted into the shift register from the LSB end, so the first bit sampled ends up at sw_data[DATA_W-1]. The state then goes to SHIFT_HI.
- FSM state SHIFT_HI: cp=1 for CLK_DIV cycles. The bit counter increments. When DATA_W bits have been sampled, go to DONE; otherwise go to SHIFT_LO.
- FSM state DONE: one cycle. ce_n=1, cp=0. Commit per the update rule, pulse sw_valid (and sw_changed if the value differs), then go to IDLE.
- Latency from scan_tick to sw_valid: 2*CLK_DIV + 2*CLK_DIV*DATA_W + 1 cycles. With default parameters this is 73.
- cp always produces exactly DATA_W rising edges per scan. The final rising edge is harmless.
- Reset during a scan aborts it immediately. sw_data returns to 0, and the next scan starts at the next scan counter wrap.
- Constraint: SCAN_CNT_MAX+1 must exceed the scan length. This is checked by an assertion in simulation only.

Optional Feature:
Macro HC165_DEBOUNCE_EN.
- Defined: the captured word is committed only if it equals the word captured by the previous scan. sw_valid and sw_changed pulse only on a commit, so switch bounce needs two identical scans (about 40 ms) to pass. The previous-capture register resets to 0.
- Undefined: every scan commits, and sw_valid pulses once per scan.

Decomposition:
- Shared package taxi_pkg holds:
  - FSM state encoding: IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE
  - the default scan interval constant
- No sub-module. The half-period timer, bit counter and scan counter are small enough to keep inline.

Test Plan:
- Bench uses a behavioural 74HC165 model, with CHAIN_LEN=1, CLK_DIV=2 and SCAN_CNT_MAX=199.
- Bench parallel inputs 8'hA5 -> after the first scan, sw_data=8'hA5, sw_valid pulses once, sw_changed=1. pl_n low for exactly 4 cycles; 8 cp rising edges; tick-to-valid latency 2*2 + 2*2*8 + 1 = 37 cycles.
- Inputs held at 8'hA5 for a second scan -> sw_valid pulses, sw_changed=0, sw_data unchanged.
- CHAIN_LEN=2, inputs 16'h3C81 (second chip 8'h3C) -> sw_data=16'h3C81, 16 cp edges per scan.
- Assert sys_rst_n mid-SHIFT (bit 3) -> outputs immediately at reset values. After release, no cp activity until the next scan counter wrap; the next scan returns the correct word.
- HC165_DEBOUNCE_EN defined, inputs alternating 8'h0F / 8'hF0 on successive scans -> no sw_valid. Inputs held at 8'hF0 for two scans -> single sw_valid with sw_data=8'hF0 and sw_changed=1.
- SCAN_CNT_MAX=19 (shorter than the scan) -> ticks during busy are dropped, busy never re-triggers mid-scan, each completed scan yields exactly one sw_valid.
